perm_inverse_stream: RTL and testbench



---
 rtl/perm_pkg.sv | 18 +
 rtl/perm_inv_table.sv | 60 ++++++
 rtl/perm_inverse_stream.sv | 98 +++++++++
 tb/tb_perm_inverse_stream.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/perm_pkg.sv
// Shared types for the permutation-family blocks: symbol width, frame length, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package perm_pkg;

    localparam int W = 4;
    localparam int N = 1 << W;

    typedef logic [W-1:0] sym_t;

    localparam sym_t LAST_IDX = sym_t'(N - 1);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/perm_inv_table.sv
// Inverse-map register file: N x W write/async-read storage plus seen bitmap and duplicate flag.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none; the caller qualifies we_i and clr_i.
module perm_inv_table
    import perm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic we_i,
    input  sym_t waddr_i,
    input  sym_t wdata_i,
    input  sym_t raddr_i,
    output sym_t rdata_o,
    output logic seen_o,
    output logic all_seen_o,
    output logic dup_o
);

    sym_t           mem_q [N];
    logic [N-1:0]   seen_q;
    logic [N-1:0]   seen_d;
    logic           dup_q;
    logic           dup_d;

    // Table contents are only ever read where the seen bit qualifies them, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        seen_d = seen_q;
        dup_d  = dup_q;
        if (clr_i) begin
            seen_d = '0;
            dup_d  = 1'b0;
        end else if (we_i) begin
            seen_d[waddr_i] = 1'b1;
            dup_d           = dup_q | seen_q[waddr_i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= '0;
            dup_q  <= 1'b0;
        end else begin
            seen_q <= seen_d;
            dup_q  <= dup_d;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign seen_o     = seen_q[raddr_i];
    assign all_seen_o = &seen_q;
    assign dup_o      = dup_q;

endmodule

// File: rtl/perm_inverse_stream.sv
// Loads a frame of N symbols, builds inv[v] = position, then streams inv[0..N-1] with an error flag.
// Latency: first output one cycle after the last input transfer.
// Backpressure: in_ready low for the whole EMIT phase; outputs hold while out_ready is low.
module perm_inverse_stream
    import perm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  sym_t in_data,
    output logic out_valid,
    input  logic out_ready,
    output sym_t out_data,
    output logic out_last,
    output logic out_err
);

    state_t state_q;
    state_t state_d;
    sym_t   wr_idx_q;
    sym_t   wr_idx_d;
    sym_t   rd_idx_q;
    sym_t   rd_idx_d;

    logic   in_fire;
    logic   out_fire;
    logic   frame_done;
    sym_t   rdata;
    logic   rd_seen;
    logic   all_seen;
    logic   dup;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign frame_done = out_fire & (rd_idx_q == LAST_IDX);

    perm_inv_table u_table (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (frame_done),
        .we_i       (in_fire),
        .waddr_i    (in_data),
        .wdata_i    (wr_idx_q),
        .raddr_i    (rd_idx_q),
        .rdata_o    (rdata),
        .seen_o     (rd_seen),
        .all_seen_o (all_seen),
        .dup_o      (dup)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    // Both indices wrap to 0 on their final transfer through natural W-bit overflow.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = in_fire  ? wr_idx_q + 1'b1 : wr_idx_q;
        rd_idx_d = out_fire ? rd_idx_q + 1'b1 : rd_idx_q;
        case (state_q)
            LOAD: if (in_fire && (wr_idx_q == LAST_IDX)) state_d = EMIT;
            EMIT: if (frame_done)                        state_d = LOAD;
            default:                                     state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = rd_seen ? rdata : '0;
                out_last  = (rd_idx_q == LAST_IDX);
                out_err   = dup | ~all_seen;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_perm_inverse_stream.sv
// Bench for perm_inverse_stream: directed and random frames against an inverse-map reference model.
module tb_perm_inverse_stream;
    import perm_pkg::*;

    logic clk;
    logic rst;
    logic in_valid;
    logic in_ready;
    sym_t in_data;
    logic out_valid;
    logic out_ready;
    sym_t out_data;
    logic out_last;
    logic out_err;

    int   checks = 0;
    int   errors = 0;
    sym_t tb_frame [N];

    perm_inverse_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++) tb_frame[i] = sym_t'(i);
    endtask

    task automatic fill_random_perm();
        sym_t tmp;
        int   j;
        fill_identity();
        for (int i = N - 1; i > 0; i--) begin
            j           = int'($urandom_range(0, i));
            tmp         = tb_frame[i];
            tb_frame[i] = tb_frame[j];
            tb_frame[j] = tmp;
        end
    endtask

    // Presents tb_frame[0..n-1]; returns 1 time unit after the edge of the last transfer.
    task automatic send_syms(input int n, input bit gaps, input bit hold_valid);
        int budget;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = tb_frame[i];
            budget   = 0;
            while (in_ready !== 1'b1 && budget < 64) begin
                @(posedge clk); #1;
                budget++;
            end
            if (budget >= 64) check($sformatf("in_ready_timeout_%0d", i), 32'(budget), 32'(0));
            check($sformatf("load_out_valid_%0d", i), 32'(out_valid), 32'(0));
            @(posedge clk); #1;
        end
        in_valid = hold_valid;
    endtask

    // Drains one frame and compares against the inverse map computed from tb_frame.
    task automatic recv_frame(input int stall_at, input int stall_len, input bit rand_bp);
        sym_t exp_data [N];
        int   cnt [N];
        bit   exp_err;
        int   k;
        int   stalled;
        int   cyc;
        for (int v = 0; v < N; v++) begin
            exp_data[v] = '0;
            cnt[v]      = 0;
        end
        for (int i = 0; i < N; i++) begin
            exp_data[tb_frame[i]] = sym_t'(i);
            cnt[tb_frame[i]]++;
        end
        exp_err = 1'b0;
        for (int v = 0; v < N; v++) if (cnt[v] != 1) exp_err = 1'b1;

        k       = 0;
        stalled = 0;
        cyc     = 0;
        while (k < N && cyc < 400) begin
            if (k == stall_at && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            check($sformatf("out_valid_%0d", k),  32'(out_valid), 32'(1));
            check($sformatf("in_ready_emit_%0d", k), 32'(in_ready), 32'(0));
            check($sformatf("out_data_%0d", k),   32'(out_data),  32'(exp_data[k]));
            check($sformatf("out_last_%0d", k),   32'(out_last),  32'(k == N - 1));
            check($sformatf("out_err_%0d", k),    32'(out_err),   32'(exp_err));
            @(posedge clk); #1;
            if (out_ready) k++;
            cyc++;
        end
        if (k < N) check("out_timeout", 32'(k), 32'(N));
        out_ready = 1'b1;
        check("post_out_valid", 32'(out_valid), 32'(0));
        check("post_in_ready",  32'(in_ready),  32'(1));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_last",  32'(out_last),  32'(0));
        check("rst_out_err",   32'(out_err),   32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Identity
        fill_identity();
        send_syms(N, 1'b0, 1'b0);
        recv_frame(-1, 0, 1'b0);

        // Scramble
        tb_frame = '{4'd10, 4'd7, 4'd12, 4'd6, 4'd11, 4'd4, 4'd13, 4'd3,
                     4'd1, 4'd15, 4'd14, 4'd2, 4'd9, 4'd0, 4'd8, 4'd5};
        send_syms(N, 1'b0, 1'b0);
        recv_frame(-1, 0, 1'b0);

        // Rotation with a 5-cycle stall at output index 4
        for (int i = 0; i < N; i++) tb_frame[i] = sym_t'((i + 3) % N);
        send_syms(N, 1'b0, 1'b0);
        recv_frame(4, 5, 1'b0);

        // All-zero frame, then a clean identity frame
        for (int i = 0; i < N; i++) tb_frame[i] = '0;
        send_syms(N, 1'b0, 1'b0);
        recv_frame(-1, 0, 1'b0);
        fill_identity();
        send_syms(N, 1'b0, 1'b0);
        recv_frame(-1, 0, 1'b0);

        // Reset mid-load after duplicate symbols; seen/dup must not leak into the next frame
        for (int i = 0; i < N; i++) tb_frame[i] = 4'd5;
        send_syms(7, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'(1));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_out_err",   32'(out_err),   32'(0));
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("postrst_out_valid", 32'(out_valid), 32'(0));
        fill_identity();
        send_syms(N, 1'b0, 1'b0);
        recv_frame(-1, 0, 1'b0);

        // Back-to-back frames with in_valid held high
        fill_random_perm();
        send_syms(N, 1'b0, 1'b1);
        recv_frame(-1, 0, 1'b0);
        fill_random_perm();
        send_syms(N, 1'b0, 1'b1);
        recv_frame(-1, 0, 1'b0);
        in_valid = 1'b0;

        // Random permutations and arbitrary frames with random gaps and backpressure
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 0) begin
                fill_random_perm();
            end else begin
                for (int i = 0; i < N; i++) tb_frame[i] = sym_t'($urandom_range(0, N - 1));
            end
            send_syms(N, 1'b1, 1'b0);
            recv_frame(-1, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
